// File: rtl/ram_arb_pkg.sv
// Shared definitions for the RAM arbiter: FSM state encoding, default
// RAM geometry, the supported requester count and a pointer helper.
package ram_arb_pkg;

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_ACCESS = 1'b1
  } arb_state_e;

  localparam int unsigned ADDR_W_DEF  = 11;
  localparam int unsigned DATA_W_DEF  = 32;
  localparam int unsigned NUM_REQ_MAX = 4;

  // Requester indices are sized for the largest supported configuration.
  localparam int unsigned IDX_W = $clog2(NUM_REQ_MAX);

  // Advance a requester index by one, wrapping at n.
  function automatic logic [IDX_W-1:0] wrap_inc(input logic [IDX_W-1:0] idx,
                                                input int unsigned     n);
    return ((32'(idx) + 32'd1) >= n) ? '0 : idx + 1'b1;
  endfunction

endpackage

// File: rtl/ram_arbiter_rr_picker.sv
// Combinational winner selection for the RAM arbiter.
// Default: round-robin search starting at rr_ptr_i, wrapping modulo NUM_REQ.
// With RAM_ARB_FIXED_PRI_EN defined the pointer input disappears and the
// lowest requesting index always wins.
module rr_picker
  import ram_arb_pkg::*;
#(
  parameter int unsigned NUM_REQ = 2
) (
  input  logic [NUM_REQ-1:0] req_i,
`ifndef RAM_ARB_FIXED_PRI_EN
  input  logic [IDX_W-1:0]   rr_ptr_i,
`endif
  output logic [NUM_REQ-1:0] win_oh_o,
  output logic [IDX_W-1:0]   win_idx_o
);

  int unsigned base;
  logic        found;

  // Walk the candidates in priority order (base, base+1, ...) and keep the first requester.
  always_comb begin
    win_oh_o  = '0;
    win_idx_o = '0;
    found     = 1'b0;
`ifdef RAM_ARB_FIXED_PRI_EN
    base      = 0;
`else
    base      = 32'(rr_ptr_i);
`endif
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      for (int unsigned c = 0; c < NUM_REQ; c++) begin
        if (!found && req_i[c] && (((base + i) % NUM_REQ) == c)) begin
          found       = 1'b1;
          win_oh_o[c] = 1'b1;
          win_idx_o   = IDX_W'(c);
        end
      end
    end
  end

endmodule

// File: rtl/ram_arbiter.sv
// Arbiter in front of the single-port negedge-clocked data RAM.
// One access every two cycles: a grant cycle (RAM strobes registered, the RAM
// acts on the following negedge) and a completion cycle (read data captured,
// per-requester rvalid pulse). All outputs are registered.
// Build option: define RAM_ARB_FIXED_PRI_EN for fixed lowest-index-wins
// priority instead of the default round-robin.
module ram_arbiter
  import ram_arb_pkg::*;
#(
  parameter int unsigned NUM_REQ = 2,
  parameter int unsigned ADDR_W  = ADDR_W_DEF,
  parameter int unsigned DATA_W  = DATA_W_DEF
) (
  input  logic                      clock,
  input  logic                      reset_n,
  input  logic [NUM_REQ-1:0]        req,
  input  logic [NUM_REQ-1:0]        req_we,
  input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
  input  logic [NUM_REQ*DATA_W-1:0] req_wdata,
  output logic [NUM_REQ-1:0]        gnt,
  output logic [NUM_REQ-1:0]        rvalid,
  output logic [DATA_W-1:0]         rdata,
  output logic                      busy,
  output logic                      ram_cs,
  output logic                      ram_we,
  output logic [ADDR_W-1:0]         ram_addr,
  output logic [DATA_W-1:0]         ram_din,
  input  logic [DATA_W-1:0]         ram_dout
);

  arb_state_e          state_q, state_d;
  logic [IDX_W-1:0]    owner_q, owner_d;
  logic [NUM_REQ-1:0]  gnt_q, gnt_d;
  logic [NUM_REQ-1:0]  rvalid_q, rvalid_d;
  logic [DATA_W-1:0]   rdata_q, rdata_d;
  logic                busy_q, busy_d;
  logic                ram_cs_q, ram_cs_d;
  logic                ram_we_q, ram_we_d;
  logic [ADDR_W-1:0]   ram_addr_q, ram_addr_d;
  logic [DATA_W-1:0]   ram_din_q, ram_din_d;
`ifndef RAM_ARB_FIXED_PRI_EN
  logic [IDX_W-1:0]    rr_ptr_q, rr_ptr_d;
`endif

  logic [NUM_REQ-1:0]  win_oh;
  logic [IDX_W-1:0]    win_idx;

  rr_picker #(
    .NUM_REQ (NUM_REQ)
  ) u_picker (
    .req_i     (req),
`ifndef RAM_ARB_FIXED_PRI_EN
    .rr_ptr_i  (rr_ptr_q),
`endif
    .win_oh_o  (win_oh),
    .win_idx_o (win_idx)
  );

  // State and output registers; async reset drops ram_cs before any pending negedge write.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= ST_IDLE;
      owner_q    <= '0;
      gnt_q      <= '0;
      rvalid_q   <= '0;
      rdata_q    <= '0;
      busy_q     <= 1'b0;
      ram_cs_q   <= 1'b0;
      ram_we_q   <= 1'b0;
      ram_addr_q <= '0;
      ram_din_q  <= '0;
`ifndef RAM_ARB_FIXED_PRI_EN
      rr_ptr_q   <= '0;
`endif
    end else begin
      state_q    <= state_d;
      owner_q    <= owner_d;
      gnt_q      <= gnt_d;
      rvalid_q   <= rvalid_d;
      rdata_q    <= rdata_d;
      busy_q     <= busy_d;
      ram_cs_q   <= ram_cs_d;
      ram_we_q   <= ram_we_d;
      ram_addr_q <= ram_addr_d;
      ram_din_q  <= ram_din_d;
`ifndef RAM_ARB_FIXED_PRI_EN
      rr_ptr_q   <= rr_ptr_d;
`endif
    end
  end

  // Next state: grant in IDLE, complete (and capture read data) in ACCESS.
  always_comb begin
    state_d    = state_q;
    owner_d    = owner_q;
    gnt_d      = '0;
    rvalid_d   = '0;
    rdata_d    = rdata_q;
    busy_d     = 1'b0;
    ram_cs_d   = 1'b0;
    ram_we_d   = 1'b0;
    ram_addr_d = ram_addr_q;
    ram_din_d  = ram_din_q;
`ifndef RAM_ARB_FIXED_PRI_EN
    rr_ptr_d   = rr_ptr_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (|req) begin
          state_d  = ST_ACCESS;
          gnt_d    = win_oh;
          owner_d  = win_idx;
          busy_d   = 1'b1;
          ram_cs_d = 1'b1;
          for (int unsigned c = 0; c < NUM_REQ; c++) begin
            if (win_oh[c]) begin
              ram_we_d   = req_we[c];
              ram_addr_d = req_addr[c*ADDR_W +: ADDR_W];
              ram_din_d  = req_wdata[c*DATA_W +: DATA_W];
            end
          end
`ifndef RAM_ARB_FIXED_PRI_EN
          rr_ptr_d = wrap_inc(win_idx, NUM_REQ);
`endif
        end
      end
      ST_ACCESS: begin
        state_d = ST_IDLE;
        // ram_cs is still high here, so ram_dout carries the word read at the last negedge.
        if (!ram_we_q) begin
          rdata_d = ram_dout;
          for (int unsigned c = 0; c < NUM_REQ; c++) begin
            if (owner_q == IDX_W'(c)) rvalid_d[c] = 1'b1;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign gnt      = gnt_q;
  assign rvalid   = rvalid_q;
  assign rdata    = rdata_q;
  assign busy     = busy_q;
  assign ram_cs   = ram_cs_q;
  assign ram_we   = ram_we_q;
  assign ram_addr = ram_addr_q;
  assign ram_din  = ram_din_q;

endmodule

// File: tb/tb_ram_arbiter.sv
// Self-checking bench for ram_arbiter with a negedge RAM model and a
// transaction-level reference (pointer, pending access, reference memory).
module tb_ram_arbiter;

  localparam int NR = 2;
  localparam int AW = 11;
  localparam int DW = 32;

  logic              clock = 1'b0;
  logic              reset_n = 1'b0;
  logic [NR-1:0]     req = '0, req_we = '0;
  logic [NR*AW-1:0]  req_addr = '0;
  logic [NR*DW-1:0]  req_wdata = '0;
  logic [NR-1:0]     gnt, rvalid;
  logic [DW-1:0]     rdata, ram_din, ram_dout;
  logic              busy, ram_cs, ram_we;
  logic [AW-1:0]     ram_addr;

  ram_arbiter #(.NUM_REQ(NR), .ADDR_W(AW), .DATA_W(DW)) dut (
    .clock(clock), .reset_n(reset_n), .req(req), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata), .gnt(gnt), .rvalid(rvalid),
    .rdata(rdata), .busy(busy), .ram_cs(ram_cs), .ram_we(ram_we),
    .ram_addr(ram_addr), .ram_din(ram_din), .ram_dout(ram_dout)
  );

  always #5 clock = ~clock;

  // RAM model: acts on negedge when selected; a backdoor port preloads words.
  logic [DW-1:0] ram_mem [0:2047];
  logic [DW-1:0] ram_q = '0;
  logic          pl_en = 1'b0;
  logic [AW-1:0] pl_addr = '0;
  logic [DW-1:0] pl_data = '0;
  always @(negedge clock) begin
    if (pl_en) ram_mem[pl_addr] <= pl_data;
    else if (ram_cs) begin
      if (ram_we) ram_mem[ram_addr] <= ram_din;
      else        ram_q <= ram_mem[ram_addr];
    end
  end
  // A fixed junk word stands in for the undriven bus when the RAM is not selected.
  assign ram_dout = ram_cs ? ram_q : 32'h5A5A_F00D;

  // Reference model state and expected outputs.
  logic [DW-1:0] ref_mem [0:2047];
  bit            m_acc;
  int            m_ptr, m_owner;
  logic [NR-1:0] e_gnt, e_rvalid;
  logic [DW-1:0] e_rdata, e_din;
  logic [AW-1:0] e_addr;
  logic          e_busy, e_cs, e_we;
  int            n_cmp = 0, n_err = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic int pick(input logic [NR-1:0] r, input int ptr);
    int start;
`ifdef RAM_ARB_FIXED_PRI_EN
    start = 0;
`else
    start = ptr;
`endif
    for (int k = 0; k < NR; k++) begin
      int c;
      c = (start + k) % NR;
      if (r[c]) return c;
    end
    return -1;
  endfunction

  task automatic model_reset();
    m_acc = 0; m_ptr = 0; m_owner = 0;
    e_gnt = '0; e_rvalid = '0; e_rdata = '0; e_din = '0; e_addr = '0;
    e_busy = 0; e_cs = 0; e_we = 0;
  endtask

  // One edge of the transaction model, using the inputs the DUT just sampled.
  task automatic model_step();
    int  w;
    bit  was_we;
    if (!reset_n) begin model_reset(); return; end
    e_gnt = '0; e_rvalid = '0; e_busy = 0; e_cs = 0;
    if (!m_acc) begin
      e_we = 0;
      if (req != '0) begin
        w = pick(req, m_ptr);
        e_gnt[w] = 1'b1; e_cs = 1; e_busy = 1; e_we = req_we[w];
        e_addr = req_addr[w*AW +: AW];
        e_din  = req_wdata[w*DW +: DW];
        m_acc = 1; m_owner = w; m_ptr = (w + 1) % NR;
      end
    end else begin
      was_we = e_we; e_we = 0; m_acc = 0;
      if (was_we) ref_mem[e_addr] = e_din;
      else begin
        e_rdata = ref_mem[e_addr];
        e_rvalid[m_owner] = 1'b1;
      end
    end
  endtask

  task automatic check_outputs();
    check_eq("gnt", 32'(gnt), 32'(e_gnt));
    check_eq("rvalid", 32'(rvalid), 32'(e_rvalid));
    check_eq("rdata", rdata, e_rdata);
    check_eq("busy", 32'(busy), 32'(e_busy));
    check_eq("ram_cs", 32'(ram_cs), 32'(e_cs));
    check_eq("ram_we", 32'(ram_we), 32'(e_we));
    check_eq("ram_addr", 32'(ram_addr), 32'(e_addr));
    check_eq("ram_din", ram_din, e_din);
  endtask

  task automatic cycle();
    @(posedge clock); #1;
    model_step();
    check_outputs();
  endtask

  task automatic poke(input logic [AW-1:0] a, input logic [DW-1:0] d);
    pl_addr = a; pl_data = d; pl_en = 1'b1;
    @(negedge clock); #1;
    pl_en = 1'b0;
    ref_mem[a] = d;
  endtask

  task automatic set_req(input int i, input bit we, input logic [AW-1:0] a, input logic [DW-1:0] d);
    req[i] = 1'b1; req_we[i] = we;
    req_addr[i*AW +: AW] = a;
    req_wdata[i*DW +: DW] = d;
  endtask

  task automatic rand_req(input int i);
    logic [AW-1:0] a;
    a = ($urandom_range(0, 1) == 1) ? {6'h3F, 5'($urandom)} : {6'h00, 5'($urandom)};
    set_req(i, bit'($urandom_range(0, 1)), a, $urandom);
  endtask

  int order[$];
  int gcyc[$];

  initial begin
    for (int a = 0; a < 2048; a++) ref_mem[a] = '0;
    model_reset();
    // Preload the address windows used below while the arbiter is held in reset.
    for (int a = 0; a < 32; a++) begin
      poke(11'(a), $urandom);
      poke(11'(a) | 11'h7E0, $urandom);
    end
    poke(11'h005, 32'hDEAD_BEEF);
    poke(11'h010, 32'h0BAD_CAFE);
    #1; check_outputs();                      // reset state
    @(posedge clock); #1; reset_n = 1'b1;
    cycle();

    // Single read on requester 0.
    set_req(0, 0, 11'h005, '0);
    cycle();
    check_eq("rd_gnt", 32'(gnt), 32'h1);
    check_eq("rd_cs", 32'(ram_cs), 32'h1);
    check_eq("rd_we", 32'(ram_we), 32'h0);
    req = '0;
    cycle();
    check_eq("rd_rvalid", 32'(rvalid), 32'h1);
    check_eq("rd_data", rdata, 32'hDEAD_BEEF);
    check_eq("rd_cs_off", 32'(ram_cs), 32'h0);

    // Write then read on requester 1.
    set_req(1, 1, 11'h7FF, 32'h1234_5678);
    cycle();
    check_eq("wr_gnt", 32'(gnt), 32'h2);
    req = '0;
    cycle();
    check_eq("wr_norv", 32'(rvalid), 32'h0);
    check_eq("wr_mem", ram_mem[11'h7FF], 32'h1234_5678);
    set_req(1, 0, 11'h7FF, '0);
    cycle();
    req = '0;
    cycle();
    check_eq("wr_rd_rvalid", 32'(rvalid), 32'h2);
    check_eq("wr_rd_data", rdata, 32'h1234_5678);

    // Contention: both requesters held for four grants.
    set_req(0, 0, 11'h001, '0);
    set_req(1, 0, 11'h002, '0);
    for (int k = 0; k < 8; k++) begin
      cycle();
      for (int i = 0; i < NR; i++) if (gnt[i]) begin order.push_back(i); gcyc.push_back(k); end
    end
    req = '0;
    check_eq("cont_n", 32'(order.size()), 32'd4);
    for (int g = 0; g < order.size() && g < 4; g++) begin
`ifdef RAM_ARB_FIXED_PRI_EN
      check_eq($sformatf("cont_who%0d", g), 32'(order[g]), 32'd0);
`else
      check_eq($sformatf("cont_who%0d", g), 32'(order[g]), 32'(g % 2));
`endif
      check_eq($sformatf("cont_cyc%0d", g), 32'(gcyc[g]), 32'(2 * g));
    end

    // Back-to-back: requester 0 keeps requesting.
    set_req(0, 0, 11'h003, '0);
    for (int k = 0; k < 8; k++) begin
      cycle();
      check_eq($sformatf("b2b_busy%0d", k), 32'(busy), 32'(k % 2 == 0));
    end
    req = '0;
    cycle();

    // Reset between the grant edge and the RAM negedge of a write.
    set_req(1, 1, 11'h010, 32'hAAAA_5555);
    cycle();
    req = '0;
    reset_n = 1'b0;
    #1;
    model_reset();
    check_eq("rst_cs_now", 32'(ram_cs), 32'h0);
    check_outputs();
    cycle();
    cycle();
    check_eq("rst_mem", ram_mem[11'h010], 32'h0BAD_CAFE);
    check_eq("rst_ref", ram_mem[11'h010], ref_mem[11'h010]);
    set_req(0, 0, 11'h004, '0);
    set_req(1, 0, 11'h006, '0);
    @(posedge clock); #1; reset_n = 1'b1;
    cycle();
    check_eq("rst_first_gnt", 32'(gnt), 32'h1);
    req = '0;
    cycle();

    // Idle bus: rdata must hold despite the junk on ram_dout.
    for (int k = 0; k < 10; k++) begin
      cycle();
      check_eq("idle_cs", 32'(ram_cs), 32'h0);
    end

    // Randomized traffic; requesters only change req when idle or just granted.
    for (int k = 0; k < 400; k++) begin
      cycle();
      for (int i = 0; i < NR; i++) begin
        if (e_gnt[i] || !req[i]) begin
          if ($urandom_range(0, 99) < 55) rand_req(i);
          else req[i] = 1'b0;
        end
      end
    end
    req = '0;
    cycle();
    cycle();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/ram_arbiter.md
Name: ram_arbiter

Overview:
- Shares the single-port 2048x32 data RAM (negedge-clocked, chip-select/write-enable interface) between NUM_REQ requesters, such as CPU fetch, CPU data and I/O.
- Sits between the requesters and the RAM instance and is the only driver of the RAM control/address/data inputs.
- Grants one access per two cycles, round-robin by default, and returns read data with a per-requester valid pulse.

Parameters:
NUM_REQ, 2, number of requesters (2..4)
ADDR_W, 11, RAM address width (2048 words)
DATA_W, 32, RAM word width

Ports:
clock  in  1  system clock; arbiter logic on posedge, RAM on negedge
reset_n  in  1  asynchronous active-low reset
req  in  NUM_REQ  request per requester; held until gnt
req_we  in  NUM_REQ  1=write, 0=read; stable while req high
req_addr  in  NUM_REQ*ADDR_W  packed addresses, requester i at [i*ADDR_W +: ADDR_W]
req_wdata  in  NUM_REQ*DATA_W  packed write data, same packing
gnt  out  NUM_REQ  one-hot, one-cycle grant pulse
rvalid  out  NUM_REQ  one-hot, one-cycle read-data-valid pulse
rdata  out  DATA_W  shared read data; holds last read value
busy  out  1  high while in ACCESS
ram_cs  out  1  RAM chip_select
ram_we  out  1  RAM write enable
ram_addr  out  ADDR_W  RAM address
ram_din  out  DATA_W  RAM write data
ram_dout  in  DATA_W  RAM read data; high-Z when not selected

Behaviour:
- Reset (async, reset_n=0): state=IDLE, rr_ptr=0, and all outputs 0 (gnt, rvalid, rdata, busy, ram_cs, ram_we, ram_addr, ram_din).
- FSM has two states, IDLE and ACCESS, with all outputs registered.
- IDLE, posedge N, with req != 0:
  - Pick the winner w: the first requester with req set, searching from rr_ptr upward modulo NUM_REQ.
  - Register ram_cs=1, ram_we=req_we[w], ram_addr/ram_din from slot w, gnt[w]=1, owner=w, busy=1.
  - Go to ACCESS.
  - Set rr_ptr=(w+1) mod NUM_REQ.
- IDLE with req==0: stay in IDLE; ram_cs=0, gnt=0.
- RAM performs the access at the negedge inside cycle N.
- ACCESS, posedge N+1:
  - Clear ram_cs, ram_we, gnt and busy; return to IDLE.
  - If the access was a read: rdata<=ram_dout and rvalid[owner]=1 for one cycle.
  - A write produces no rvalid.
- Requests are ignored in ACCESS. A requester sees gnt during cycle N and must drop or replace req by posedge N+1. The next arbitration happens at posedge N+2.
- Throughput: one access per 2 cycles.
- Read latency: req sampled at posedge N gives rvalid high in cycle N+1.
- rdata is sampled only on a read completion, never while ram_cs=0 (RAM output is high-Z then).
- Simultaneous requests: exactly one grant; the others wait with req held. No starvation, since each requester waits at most NUM_REQ-1 grants.
- rr_ptr wraps from NUM_REQ-1 to 0.
- Reset mid-operation: ram_cs clears immediately. A write whose negedge has not yet occurred is suppressed, and no rvalid is issued for an aborted read.
- An address is used unmodified, with no bounds check; it is ADDR_W wide by construction.

Optional Feature:
- Macro: RAM_ARB_FIXED_PRI_EN.
- Defined: fixed priority, lowest index wins. rr_ptr is removed and requester 0 can starve the others.
- Undefined: round-robin as described above.
- Timing and handshake are identical in both modes.

Decomposition:
- Shared package/header ram_arb_pkg holds:
  - the state encoding (IDLE=1'b0, ACCESS=1'b1)
  - default ADDR_W/DATA_W constants
  - the NUM_REQ maximum
- One combinational sub-module, rr_picker, is natural. Inputs: req and rr_ptr. Outputs: one-hot winner and its index. It also implements the fixed-priority variant under the macro.

Test Plan:
- Single read: preload mem[0x005]=0xDEADBEEF; req[0], read, addr 0x005 -> gnt[0] in cycle N; ram_cs=1 and ram_we=0 in cycle N; rvalid[0]=1 and rdata=0xDEADBEEF in cycle N+1; ram_cs=0 in cycle N+1.
- Write then read: req[1] writes 0x12345678 to 0x7FF, then reads 0x7FF -> mem[0x7FF]=0x12345678; rvalid[1] with rdata=0x12345678; no rvalid after the write.
- Contention: req=2'b11 held for 4 grants -> round-robin grant order 0,1,0,1 with 2-cycle spacing. Under RAM_ARB_FIXED_PRI_EN the order is 0,0,0,0.
- Back-to-back: req[0] reissued immediately after each gnt -> a grant every 2 cycles; busy toggles 1,0,1,0.
- Reset mid-write: assert reset_n=0 between the posedge grant and the negedge of a write of 0xAAAA5555 to 0x010 -> ram_cs=0 at once; mem[0x010] unchanged; all outputs 0; first grant after release goes to requester 0.
- Idle bus: req=0 for 10 cycles -> ram_cs=0, gnt=0, rvalid=0; rdata holds its previous value even though ram_dout is high-Z.
